// File: rtl/mem_arbiter.sv
// Two-requester (I-cache / D-cache) arbiter in front of a single-port memory.
// Tie resolution: define ARB_RR_EN for round-robin, otherwise D has fixed priority.
module mem_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_strobe,
    input  logic        i_rw,
    input  logic [31:0] i_address,
    output logic        i_ready,
    output logic [31:0] i_data_out,
    input  logic        d_strobe,
    input  logic        d_rw,
    input  logic [31:0] d_address,
    input  logic [31:0] d_data_in,
    output logic        d_ready,
    output logic [31:0] d_data_out,
    output logic        mem_enable,
    output logic        mem_read,
    output logic        mem_write,
    output logic [11:0] mem_address,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out,
    input  logic        mem_ready,
    output logic        arb_timeout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_grant_i;
    logic        w_grant_d;
    logic        w_busy;
    logic        r_rw;
    logic [11:0] r_addr;
    logic [31:0] r_data;
    logic [7:0]  r_wait;
    logic        r_timeout;
    logic        w_unused;

    assign w_unused = &{1'b0, i_address[31:12], d_address[31:12]};

`ifdef ARB_RR_EN
    logic r_last_d;  // 1 when D received the most recent grant

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_last_d <= 1'b0;
        else if (w_grant_d)
            r_last_d <= 1'b1;
        else if (w_grant_i)
            r_last_d <= 1'b0;
    end
`endif

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == IDLE) begin
            if (i_strobe && d_strobe) begin
`ifdef ARB_RR_EN
                w_grant_d = ~r_last_d;
                w_grant_i = r_last_d;
`else
                w_grant_d = 1'b1;
`endif
            end else begin
                w_grant_i = i_strobe;
                w_grant_d = d_strobe;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d)
                    w_next = BUSY_D;
                else if (w_grant_i)
                    w_next = BUSY_I;
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rw   <= 1'b1;
            r_addr <= '0;
            r_data <= '0;
        end else if (w_grant_d) begin
            r_rw   <= d_rw;
            r_addr <= d_address[11:0];
            r_data <= d_data_in;
        end else if (w_grant_i) begin
            r_rw   <= i_rw;
            r_addr <= i_address[11:0];
            r_data <= '0;
        end
    end

    // Flag rises on the same edge the saturating counter reaches 255.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else if (w_grant_i || w_grant_d) begin
            r_wait <= '0;
        end else if (w_busy && !mem_ready && (r_wait != 8'hFF)) begin
            r_wait <= r_wait + 8'd1;
            if (r_wait == 8'hFE)
                r_timeout <= 1'b1;
        end
    end

    always_comb begin
        w_busy      = (r_state == BUSY_I) || (r_state == BUSY_D);
        mem_enable  = w_busy;
        mem_read    = w_busy ? r_rw : 1'b1;
        mem_write   = w_busy & ~r_rw;
        mem_address = r_addr;
        mem_data_in = r_data;
        i_ready     = mem_ready & (r_state == BUSY_I);
        d_ready     = mem_ready & (r_state == BUSY_D);
        i_data_out  = mem_data_out;
        d_data_out  = mem_data_out;
        arb_timeout = r_timeout;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter; honours ARB_RR_EN for the tie-order check.
module tb_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        i_strobe, i_rw, i_ready;
    logic [31:0] i_address, i_data_out;
    logic        d_strobe, d_rw, d_ready;
    logic [31:0] d_address, d_data_in, d_data_out;
    logic        mem_enable, mem_read, mem_write, mem_ready, arb_timeout;
    logic [11:0] mem_address;
    logic [31:0] mem_data_in, mem_data_out;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clock = ~clock;

    mem_arbiter dut (
        .clock        (clock),
        .reset        (reset),
        .i_strobe     (i_strobe),
        .i_rw         (i_rw),
        .i_address    (i_address),
        .i_ready      (i_ready),
        .i_data_out   (i_data_out),
        .d_strobe     (d_strobe),
        .d_rw         (d_rw),
        .d_address    (d_address),
        .d_data_in    (d_data_in),
        .d_ready      (d_ready),
        .d_data_out   (d_data_out),
        .mem_enable   (mem_enable),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .mem_ready    (mem_ready),
        .arb_timeout  (arb_timeout)
    );

    typedef struct {
        logic        is;
        logic [31:0] ia;
        logic        ds;
        logic        drw;
        logic [31:0] da;
        logic [31:0] dd;
        logic        mr;
        logic [31:0] md;
        logic        en;
        logic        rd;
        logic        wr;
        logic [11:0] ma;
        logic [31:0] mdi;
        logic        ir;
        logic        dr;
    } vec_t;

    vec_t tv[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        byte         got[4];
        int unsigned n_got;
        logic        saw_ready;

        //        is    ia             ds    drw   da             dd             mr    md             en    rd    wr    ma       mdi            ir    dr
        tv[0]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0A14, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 12'h000, 32'h0,         1'b0, 1'b0};
        tv[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0A14, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 12'hA14, 32'h0,         1'b0, 1'b0};
        tv[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0A14, 32'h0,         1'b1, 32'hDEADBEEF,  1'b1, 1'b1, 1'b0, 12'hA14, 32'h0,         1'b0, 1'b1};
        tv[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0A14, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 12'hA14, 32'h0,         1'b0, 1'b0};
        tv[4]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0B20, 32'h12345678,  1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 12'hA14, 32'h0,         1'b0, 1'b0};
        tv[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0B20, 32'h12345678,  1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 12'hB20, 32'h12345678,  1'b0, 1'b0};
        tv[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0B20, 32'h12345678,  1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 12'hB20, 32'h12345678,  1'b0, 1'b0};
        tv[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0B20, 32'h12345678,  1'b1, 32'h0,         1'b1, 1'b0, 1'b1, 12'hB20, 32'h12345678,  1'b0, 1'b1};
        tv[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0B20, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 12'hB20, 32'h12345678,  1'b0, 1'b0};
        tv[9]  = '{1'b1, 32'hFFFF_1234, 1'b0, 1'b1, 32'h0000_0B20, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 12'hB20, 32'h12345678,  1'b0, 1'b0};
        tv[10] = '{1'b1, 32'hFFFF_1234, 1'b1, 1'b1, 32'h0000_0FFC, 32'h0,         1'b1, 32'hCAFEF00D,  1'b1, 1'b1, 1'b0, 12'h234, 32'h0,         1'b1, 1'b0};
        tv[11] = '{1'b0, 32'hFFFF_1234, 1'b1, 1'b1, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 12'h234, 32'h0,         1'b0, 1'b0};
        tv[12] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0FFC, 32'h0,         1'b1, 32'h0BADF00D,  1'b1, 1'b1, 1'b0, 12'hFFC, 32'h0,         1'b0, 1'b1};
        tv[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 12'hFFC, 32'h0,         1'b0, 1'b0};

        i_strobe = 1'b0; i_rw = 1'b1; i_address = '0;
        d_strobe = 1'b0; d_rw = 1'b1; d_address = '0; d_data_in = '0;
        mem_ready = 1'b0; mem_data_out = '0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        check("reset_state", {mem_enable, mem_read, mem_write, mem_address, mem_data_in, arb_timeout},
              {1'b0, 1'b1, 1'b0, 12'h000, 32'h0, 1'b0});
        reset = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            i_strobe = tv[i].is; i_address = tv[i].ia;
            d_strobe = tv[i].ds; d_rw = tv[i].drw; d_address = tv[i].da; d_data_in = tv[i].dd;
            mem_ready = tv[i].mr; mem_data_out = tv[i].md;
            #1;
            check($sformatf("vec%0d_ctrl", i),
                  {mem_enable, mem_read, mem_write, mem_address, mem_data_in, i_ready, d_ready},
                  {tv[i].en, tv[i].rd, tv[i].wr, tv[i].ma, tv[i].mdi, tv[i].ir, tv[i].dr});
            check($sformatf("vec%0d_rdata", i), {i_data_out, d_data_out}, {tv[i].md, tv[i].md});
        end

        // Both strobes held with instant memory: observe the grant order.
        pulse_reset();
        @(negedge clock);
        i_strobe = 1'b1; d_strobe = 1'b1; mem_ready = 1'b1;
        n_got = 0;
        for (int c = 0; c < 40 && n_got < 4; c++) begin
            #1;
            if (d_ready && n_got < 4) begin got[n_got] = "D"; n_got++; end
            if (i_ready && n_got < 4) begin got[n_got] = "I"; n_got++; end
            @(negedge clock);
        end
        check("grant_count", 64'(n_got), 64'd4);
`ifdef ARB_RR_EN
        check("grant_order", {got[0], got[1], got[2], got[3]}, "DIDI");
`else
        check("grant_order", {got[0], got[1], got[2], got[3]}, "DDDD");
`endif
        i_strobe = 1'b0; d_strobe = 1'b0; mem_ready = 1'b0;

        // Reset in the middle of an I access.
        pulse_reset();
        @(negedge clock);
        i_strobe = 1'b1; i_address = 32'h0000_0777; i_rw = 1'b1;
        @(negedge clock);
        #1;
        check("busy_i_before_reset", {mem_enable, mem_address, i_ready}, {1'b1, 12'h777, 1'b0});
        #2;
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        check("async_reset_mid_access", {mem_enable, mem_read, mem_write, mem_address, i_ready},
              {1'b1 ^ 1'b1, 1'b1, 1'b0, 12'h000, 1'b0});
        i_strobe = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        saw_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (i_ready || mem_enable) saw_ready = 1'b1;
            @(negedge clock);
        end
        check("no_ready_after_reset", {63'd0, saw_ready}, 64'd0);
        mem_ready = 1'b0;

        // Memory withholds ready for 300 cycles.
        pulse_reset();
        #1;
        check("timeout_clear_after_reset", {63'd0, arb_timeout}, 64'd0);
        @(negedge clock);
        d_strobe = 1'b1; d_rw = 1'b1; d_address = 32'h0000_0055;
        @(negedge clock);
        repeat (254) @(negedge clock);
        #1;
        check("timeout_at_254", {mem_enable, arb_timeout}, {1'b1, 1'b0});
        @(negedge clock);
        #1;
        check("timeout_at_255", {mem_enable, arb_timeout}, {1'b1, 1'b1});
        repeat (44) @(negedge clock);
        mem_ready = 1'b1;
        #1;
        check("timeout_completion", {mem_enable, d_ready, arb_timeout}, {1'b1, 1'b1, 1'b1});
        @(negedge clock);
        d_strobe = 1'b0; mem_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("timeout_sticky", {mem_enable, arb_timeout}, {1'b0, 1'b1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

endmodule
